fifo_ring: RTL and testbench
============================

// Module: fifo_ring
//
// PURPOSE
//   Ring-buffer FIFO with ready/valid ports on both sides, any depth >= 2
//   (power of two not required), and first-word-fall-through reads.
//   Adds occupancy count, registered almost-full/almost-empty flags and a
//   synchronous flush, none of which the register-chain FIFO provides.
//   Sits between producer and consumer pipelines as the general buffering
//   element; the register-chain FIFO remains for very shallow cases.
//
// PARAMETERS
//   FIFO_REG_WIDTH   8   data width in bits (>= 1)
//   FIFO_DEPTH       16  number of entries (>= 2)
//   AFULL_LEVEL      12  o_almost_full asserted when count >= AFULL_LEVEL (1..FIFO_DEPTH)
//   AEMPTY_LEVEL     2   o_almost_empty asserted when count <= AEMPTY_LEVEL (0..FIFO_DEPTH-1)
//   CW = $clog2(FIFO_DEPTH+1) (localparam); PW = max(1,$clog2(FIFO_DEPTH)) (localparam)
//
// PORTS
//   i_clock         in   1               single clock; all state changes on rising edge
//   i_reset         in   1               synchronous, active-high reset
//   i_flush         in   1               synchronous discard of all contents
//   i_read_ready    in   1               consumer accepts head word this cycle
//   o_read_valid    out  1               head word valid (count != 0)
//   o_read_data     out  FIFO_REG_WIDTH  head word; don't-care when o_read_valid=0
//   o_write_ready   out  1               FIFO can accept a word (count != FIFO_DEPTH)
//   i_write_valid   in   1               producer presents word
//   i_write_data    in   FIFO_REG_WIDTH  write word
//   o_count         out  CW              current occupancy, 0..FIFO_DEPTH
//   o_almost_full   out  1               registered, see AFULL_LEVEL
//   o_almost_empty  out  1               registered, see AEMPTY_LEVEL
//
// BEHAVIOUR
//   - Reset: wr_ptr=rd_ptr=0, o_count=0, o_read_valid=0, o_almost_full=0,
//     o_almost_empty=1. o_write_ready forced 0 while i_reset=1, else 1 when not full.
//     Storage array not reset; contents irrelevant once count=0.
//   - wr = i_write_valid & o_write_ready; rd = i_read_valid & i_read_ready,
//     where i_read_valid means o_read_valid. Transfers occur on the edge where
//     the respective condition holds.
//   - wr: mem[wr_ptr] <= i_write_data; wr_ptr <= (wr_ptr==FIFO_DEPTH-1) ? 0 : wr_ptr+1.
//   - rd: rd_ptr advances with the same wrap rule; o_read_data = mem[rd_ptr]
//     (combinational read, FWFT).
//   - Latency: word written at edge N is visible on o_read_data/o_read_valid
//     after edge N (1 cycle write->read). No same-cycle bypass when empty.
//   - count_next = count + wr - rd. wr&rd together leaves count unchanged,
//     legal at any occupancy 1..FIFO_DEPTH-1; when full only rd can occur
//     (o_write_ready=0), when empty only wr can occur (o_read_valid=0).
//   - o_write_ready and o_read_valid depend only on registered count (no
//     combinational path from i_read_ready or i_write_valid).
//   - Flags register from count_next: o_almost_full <= count_next >= AFULL_LEVEL;
//     o_almost_empty <= count_next <= AEMPTY_LEVEL. Always consistent with o_count.
//   - Precedence: i_reset > i_flush > transfers. i_flush=1 zeroes pointers and count,
//     sets flags as at reset, and discards any write/read that cycle (producer
//     sees ready=1 but word is dropped; this is the documented flush contract).
//   - Reset or flush mid-stream: a word presented in that cycle is lost;
//     operation resumes normally on the following cycle.
//   - Pointer wrap correct for non-power-of-two FIFO_DEPTH; pointers never reach FIFO_DEPTH.
//   - Simulation assertions: count never exceeds FIFO_DEPTH; parameter range check at elaboration.
//
// TESTING (FIFO_REG_WIDTH=8, FIFO_DEPTH=5, AFULL_LEVEL=4, AEMPTY_LEVEL=1)
//   1 Write 0x11..0x15 with read_ready=0 -> count 1..5, ready=0 after 5th, afull at count 4;
//     6th write held off; then drain -> reads 0x11..0x15 in order, valid=0, aempty=1.
//   2 Write 0xA0 into empty FIFO at edge N -> o_read_valid=0 before N, =1 with data 0xA0 after N.
//   3 Fill 3, then 20 cycles wr&rd every cycle (0x30..0x43) -> count stays 3; output
//     order exact; pointers wrap 4 times through index 4->0 without error.
//   4 Full (5 words), assert read_ready and write_valid together -> one read,
//     no write; next cycle count=4, ready=1, write accepted.
//   5 Count=3, pulse i_flush with write_valid=1 data 0x77 -> next cycle count=0,
//     valid=0, aempty=1, 0x77 never read out; a subsequent write reads back correctly.
//   6 Count=4, assert i_reset for 1 cycle -> outputs at reset values; write_ready=0 during
//     reset, =1 after; old data never appears.

Source files
------------

// File: rtl/fifo_ring.sv
// fifo_ring: ring-buffer FIFO with ready/valid handshakes on both sides,
// first-word-fall-through reads, occupancy count, registered almost-full /
// almost-empty flags and a synchronous flush. Depth need not be a power of two.
module fifo_ring #(
    parameter int FIFO_REG_WIDTH = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int AFULL_LEVEL    = 12,
    parameter int AEMPTY_LEVEL   = 2
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_flush,
    input  logic                          i_read_ready,
    output logic                          o_read_valid,
    output logic [FIFO_REG_WIDTH-1:0]     o_read_data,
    output logic                          o_write_ready,
    input  logic                          i_write_valid,
    input  logic [FIFO_REG_WIDTH-1:0]     i_write_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
    output logic                          o_almost_full,
    output logic                          o_almost_empty
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);
    localparam logic [PW-1:0] LAST_C   = PW'(FIFO_DEPTH - 1);

`ifndef SYNTHESIS
    // Elaboration-time parameter range checks.
    if (FIFO_REG_WIDTH < 1) begin : g_bad_width
        $error("fifo_ring: FIFO_REG_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("fifo_ring: FIFO_DEPTH must be >= 2");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > FIFO_DEPTH) begin : g_bad_afull
        $error("fifo_ring: AFULL_LEVEL must be in 1..FIFO_DEPTH");
    end
    if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("fifo_ring: AEMPTY_LEVEL must be in 0..FIFO_DEPTH-1");
    end
`endif

    // Storage is deliberately not reset; a zero count makes its contents irrelevant.
    logic [FIFO_REG_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_inc;
    logic [PW-1:0] rd_ptr_inc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          wr;
    logic          rd;
    logic          clear;

    // Handshake signals depend only on registered count (and reset for write side).
    always_comb begin
        o_read_valid  = (count != '0);
        o_write_ready = !i_reset && (count != DEPTH_C);
        wr            = i_write_valid && o_write_ready;
        rd            = o_read_valid && i_read_ready;
        clear         = i_reset || i_flush;
    end

    // Pointer increments wrap explicitly at FIFO_DEPTH-1 so any depth works.
    always_comb begin
        wr_ptr_inc = (wr_ptr == LAST_C) ? '0 : wr_ptr + PW'(1);
        rd_ptr_inc = (rd_ptr == LAST_C) ? '0 : rd_ptr + PW'(1);
    end

    // Next occupancy; reset/flush override any transfer in the same cycle.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (wr && !rd) begin
            count_next = count + CW'(1);
        end else if (rd && !wr) begin
            count_next = count - CW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge i_clock) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (rd) begin
                rd_ptr <= rd_ptr_inc;
            end
        end
        count <= count_next;
    end

    // Storage write; a word offered during reset or flush is dropped.
    always_ff @(posedge i_clock) begin
        if (wr && !clear) begin
            mem[wr_ptr] <= i_write_data;
        end
    end

    // Level flags are registered from count_next so they track o_count exactly.
    always_ff @(posedge i_clock) begin
        if (clear) begin
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
        end else begin
            o_almost_full  <= (count_next >= AFULL_C);
            o_almost_empty <= (count_next <= AEMPTY_C);
        end
    end

    // First-word-fall-through head and occupancy outputs.
    always_comb begin
        o_read_data = mem[rd_ptr];
        o_count     = count;
    end

`ifndef SYNTHESIS
    // Occupancy and pointer sanity checks.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            assert (count <= DEPTH_C)
                else $error("fifo_ring: count %0d exceeds depth", count);
            assert (wr_ptr <= LAST_C && rd_ptr <= LAST_C)
                else $error("fifo_ring: pointer out of range");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ring.sv
// tb_fifo_ring: directed scenario bench for fifo_ring at depth 5,
// almost-full level 4, almost-empty level 1.
module tb_fifo_ring;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       read_ready;
    logic       read_valid;
    logic [7:0] read_data;
    logic       write_ready;
    logic       write_valid;
    logic [7:0] write_data;
    logic [2:0] count;
    logic       almost_full;
    logic       almost_empty;

    int checks = 0;
    int errors = 0;

    fifo_ring #(
        .FIFO_REG_WIDTH (8),
        .FIFO_DEPTH     (5),
        .AFULL_LEVEL    (4),
        .AEMPTY_LEVEL   (1)
    ) dut (
        .i_clock        (clk),
        .i_reset        (reset),
        .i_flush        (flush),
        .i_read_ready   (read_ready),
        .o_read_valid   (read_valid),
        .o_read_data    (read_data),
        .o_write_ready  (write_ready),
        .i_write_valid  (write_valid),
        .i_write_data   (write_data),
        .o_count        (count),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write one word with reads held off.
    task automatic push(input logic [7:0] d);
        write_valid = 1'b1;
        write_data  = d;
        read_ready  = 1'b0;
        step();
        write_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (write_ready !== 1'b0) begin
            errors++; $display("FAIL reset_wready got %b want 0", write_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || read_valid !== 1'b0 || almost_full !== 1'b0 ||
            almost_empty !== 1'b1 || write_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d v=%b af=%b ae=%b wr=%b want 0 0 0 1 1",
                     count, read_valid, almost_full, almost_empty, write_ready);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 8'h11 + 8'(i);
            checks++;
            if (write_ready !== 1'b1) begin
                errors++; $display("FAIL fill_wready[%0d] got %b want 1", i, write_ready);
            end
            push(d);
            checks++;
            if (count !== 3'(i + 1) || almost_full !== (i + 1 >= 4) ||
                almost_empty !== (i + 1 <= 1)) begin
                errors++;
                $display("FAIL fill_count[%0d] got cnt=%0d af=%b ae=%b want %0d %b %b",
                         i, count, almost_full, almost_empty, i + 1, (i + 1 >= 4), (i + 1 <= 1));
            end
        end
        checks++;
        if (write_ready !== 1'b0) begin
            errors++; $display("FAIL full_wready got %b want 0", write_ready);
        end
        push(8'h99);
        checks++;
        if (count !== 3'd5) begin
            errors++; $display("FAIL sixth_write_held got cnt=%0d want 5", count);
        end
        read_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = 8'h11 + 8'(i);
            checks++;
            if (read_valid !== 1'b1 || read_data !== d) begin
                errors++;
                $display("FAIL drain_data[%0d] got v=%b d=%h want 1 %h", i, read_valid, read_data, d);
            end
            step();
        end
        read_ready = 1'b0;
        checks++;
        if (read_valid !== 1'b0 || count !== 3'd0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got v=%b cnt=%0d ae=%b af=%b want 0 0 1 0",
                     read_valid, count, almost_empty, almost_full);
        end
    endtask

    task automatic test_latency();
        write_valid = 1'b1;
        write_data  = 8'hA0;
        #1;
        checks++;
        if (read_valid !== 1'b0) begin
            errors++; $display("FAIL no_bypass got v=%b want 0", read_valid);
        end
        step();
        write_valid = 1'b0;
        checks++;
        if (read_valid !== 1'b1 || read_data !== 8'hA0 || count !== 3'd1) begin
            errors++;
            $display("FAIL write_to_read got v=%b d=%h cnt=%0d want 1 a0 1", read_valid, read_data, count);
        end
        read_ready = 1'b1;
        step();
        read_ready = 1'b0;
        checks++;
        if (read_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL latency_drain got v=%b cnt=%0d want 0 0", read_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        int bad = 0;
        push(8'h30);
        push(8'h31);
        push(8'h32);
        for (int i = 0; i < 20; i++) begin
            write_valid = 1'b1;
            write_data  = 8'h33 + 8'(i);
            read_ready  = 1'b1;
            exp_d = 8'h30 + 8'(i);
            #1;
            checks++;
            if (read_data !== exp_d) begin
                errors++; bad++;
                $display("FAIL b2b_data[%0d] got %h want %h", i, read_data, exp_d);
            end
            step();
            checks++;
            if (count !== 3'd3) begin
                errors++; bad++;
                $display("FAIL b2b_count[%0d] got %0d want 3", i, count);
            end
            if (bad > 6) break;
        end
        write_valid = 1'b0;
        read_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_d = 8'h44 + 8'(i);
            checks++;
            if (read_valid !== 1'b1 || read_data !== exp_d) begin
                errors++;
                $display("FAIL b2b_tail[%0d] got v=%b d=%h want 1 %h", i, read_valid, read_data, exp_d);
            end
            step();
        end
        read_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++; $display("FAIL b2b_empty got cnt=%0d want 0", count);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_q [5];
        exp_q = '{8'h52, 8'h53, 8'h54, 8'h55, 8'h57};
        for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
        read_ready  = 1'b1;
        write_valid = 1'b1;
        write_data  = 8'h56;
        #1;
        checks++;
        if (write_ready !== 1'b0 || read_data !== 8'h51) begin
            errors++; $display("FAIL full_rw_pre got wr=%b d=%h want 0 51", write_ready, read_data);
        end
        step();
        checks++;
        if (count !== 3'd4 || write_ready !== 1'b1 || read_data !== 8'h52) begin
            errors++;
            $display("FAIL full_rw_post got cnt=%0d wr=%b d=%h want 4 1 52", count, write_ready, read_data);
        end
        push(8'h57);
        checks++;
        if (count !== 3'd5) begin
            errors++; $display("FAIL full_rw_refill got cnt=%0d want 5", count);
        end
        read_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (read_valid !== 1'b1 || read_data !== exp_q[i]) begin
                errors++;
                $display("FAIL full_rw_order[%0d] got v=%b d=%h want 1 %h", i, read_valid, read_data, exp_q[i]);
            end
            step();
        end
        read_ready = 1'b0;
    endtask

    task automatic test_flush();
        push(8'h61);
        push(8'h62);
        push(8'h63);
        flush       = 1'b1;
        write_valid = 1'b1;
        write_data  = 8'h77;
        #1;
        checks++;
        if (write_ready !== 1'b1) begin
            errors++; $display("FAIL flush_wready got %b want 1", write_ready);
        end
        step();
        flush       = 1'b0;
        write_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || read_valid !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL flush_state got cnt=%0d v=%b ae=%b af=%b want 0 0 1 0",
                     count, read_valid, almost_empty, almost_full);
        end
        push(8'h78);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 8'h78 || count !== 3'd1) begin
            errors++;
            $display("FAIL flush_resume got v=%b d=%h cnt=%0d want 1 78 1", read_valid, read_data, count);
        end
        read_ready = 1'b1;
        step();
        read_ready = 1'b0;
        checks++;
        if (read_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL flush_final got v=%b cnt=%0d want 0 0", read_valid, count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push(8'h81 + 8'(i));
        checks++;
        if (almost_full !== 1'b1 || count !== 3'd4) begin
            errors++; $display("FAIL mid_pre got af=%b cnt=%0d want 1 4", almost_full, count);
        end
        reset       = 1'b1;
        write_valid = 1'b1;
        write_data  = 8'h99;
        #1;
        checks++;
        if (write_ready !== 1'b0) begin
            errors++; $display("FAIL mid_wready got %b want 0", write_ready);
        end
        step();
        checks++;
        if (count !== 3'd0 || read_valid !== 1'b0 || almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_state got cnt=%0d v=%b af=%b ae=%b want 0 0 0 1",
                     count, read_valid, almost_full, almost_empty);
        end
        reset       = 1'b0;
        write_valid = 1'b0;
        #1;
        checks++;
        if (write_ready !== 1'b1) begin
            errors++; $display("FAIL mid_release got wr=%b want 1", write_ready);
        end
        push(8'hC1);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 8'hC1 || count !== 3'd1) begin
            errors++;
            $display("FAIL mid_resume got v=%b d=%h cnt=%0d want 1 c1 1", read_valid, read_data, count);
        end
        read_ready = 1'b1;
        step();
        read_ready = 1'b0;
        checks++;
        if (read_valid !== 1'b0) begin
            errors++; $display("FAIL mid_final got v=%b want 0", read_valid);
        end
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        read_ready  = 1'b0;
        write_valid = 1'b0;
        write_data  = 8'h00;
        test_reset();
        test_fill_drain();
        test_latency();
        test_back_to_back();
        test_full_rw();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
